// File: rtl/mult_pkg.sv
// Shared types and constants for the multiply issue path.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } seq_state_e;

    localparam int PP_COUNT_16 = 4;
    localparam int PP_COUNT_32 = 16;
    localparam int BYTE_W      = 8;

endpackage

// File: rtl/pp_byte_select.sv
// Maps a partial-product index to the byte operands of both 8x8 multipliers and the byte weight.
module pp_byte_select
    import mult_pkg::*;
(
    input  logic [3:0]        k,
    input  logic              mode_32bit,
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    output logic [BYTE_W-1:0] mul1_a,
    output logic [BYTE_W-1:0] mul1_b,
    output logic [BYTE_W-1:0] mul2_a,
    output logic [BYTE_W-1:0] mul2_b,
    output logic [2:0]        pp_shift
);

    logic [1:0] i;
    logic [1:0] j;

    always_comb begin
        i      = 2'd0;
        j      = 2'd0;
        mul2_a = '0;
        mul2_b = '0;
        if (mode_32bit) begin
            i = k[3:2];
            j = k[1:0];
        end else begin
            i = {1'b0, k[1]};
            j = {1'b0, k[0]};
            // Lane 2 is the upper 16-bit half of each operand.
            mul2_a = a[16 + BYTE_W * int'(i[0]) +: BYTE_W];
            mul2_b = b[16 + BYTE_W * int'(j[0]) +: BYTE_W];
        end
        mul1_a   = a[BYTE_W * int'(i) +: BYTE_W];
        mul1_b   = b[BYTE_W * int'(j) +: BYTE_W];
        pp_shift = {1'b0, i} + {1'b0, j};
    end

endmodule

// File: rtl/pp_operand_sequencer.sv
// Accepts one multiply request and issues its byte partial products, one per cycle,
// then waits for the accumulator to finish (or times out).
module pp_operand_sequencer
    import mult_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int BYTE_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              mode_32bit,
    input  logic [31:0]       operand_a,
    input  logic [31:0]       operand_b,
    output logic [BYTE_W-1:0] mul1_a,
    output logic [BYTE_W-1:0] mul1_b,
    output logic [BYTE_W-1:0] mul2_a,
    output logic [BYTE_W-1:0] mul2_b,
    output logic              pp_valid,
    output logic [2:0]        pp_shift,
    output logic              pp_last,
    output logic              acc_start,
    output logic              acc_mode_32bit,
    input  logic              acc_done,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_e        state;
    seq_state_e        state_next;
    logic [31:0]       a_reg;
    logic [31:0]       b_reg;
    logic [3:0]        k;
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic              tmo_hit;
    logic [3:0]        sel_k;
    logic              sel_mode;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic              sel_last;
    logic [BYTE_W-1:0] sel_m1a;
    logic [BYTE_W-1:0] sel_m1b;
    logic [BYTE_W-1:0] sel_m2a;
    logic [BYTE_W-1:0] sel_m2b;
    logic [2:0]        sel_shift;

    assign op_ready = (state == IDLE);
    assign busy     = ~op_ready;
    assign accept   = op_valid && op_ready;
    assign tmo_hit  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // In IDLE the first product is taken straight from the inputs so it is registered at accept.
    assign sel_k    = (state == IDLE) ? 4'd0 : k;
    assign sel_mode = (state == IDLE) ? mode_32bit : acc_mode_32bit;
    assign sel_a    = (state == IDLE) ? operand_a : a_reg;
    assign sel_b    = (state == IDLE) ? operand_b : b_reg;
    assign sel_last = sel_mode ? (sel_k == 4'(PP_COUNT_32 - 1))
                               : (sel_k == 4'(PP_COUNT_16 - 1));

    pp_byte_select u_sel (
        .k          (sel_k),
        .mode_32bit (sel_mode),
        .a          (sel_a),
        .b          (sel_b),
        .mul1_a     (sel_m1a),
        .mul1_b     (sel_m1b),
        .mul2_a     (sel_m2a),
        .mul2_b     (sel_m2b),
        .pp_shift   (sel_shift)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept) state_next = ISSUE;
            ISSUE:     if (pp_last) state_next = WAIT_DONE;
            WAIT_DONE: if (acc_done || tmo_hit) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg          <= '0;
            b_reg          <= '0;
            k              <= '0;
            cnt            <= '0;
            pp_valid       <= 1'b0;
            pp_last        <= 1'b0;
            pp_shift       <= '0;
            acc_start      <= 1'b0;
            acc_mode_32bit <= 1'b0;
            timeout_err    <= 1'b0;
            mul1_a         <= '0;
            mul1_b         <= '0;
            mul2_a         <= '0;
            mul2_b         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg          <= operand_a;
                        b_reg          <= operand_b;
                        acc_mode_32bit <= mode_32bit;
                        timeout_err    <= 1'b0;
                        k              <= 4'd1;
                        cnt            <= '0;
                        pp_valid       <= 1'b1;
                        acc_start      <= 1'b1;
                        pp_last        <= sel_last;
                        pp_shift       <= sel_shift;
                        mul1_a         <= sel_m1a;
                        mul1_b         <= sel_m1b;
                        mul2_a         <= sel_m2a;
                        mul2_b         <= sel_m2b;
                    end
                end
                ISSUE: begin
                    acc_start <= 1'b0;
                    if (pp_last) begin
                        pp_valid <= 1'b0;
                        pp_last  <= 1'b0;
                        pp_shift <= '0;
                        mul1_a   <= '0;
                        mul1_b   <= '0;
                        mul2_a   <= '0;
                        mul2_b   <= '0;
                    end else begin
                        k        <= k + 4'd1;
                        pp_last  <= sel_last;
                        pp_shift <= sel_shift;
                        mul1_a   <= sel_m1a;
                        mul1_b   <= sel_m1b;
                        mul2_a   <= sel_m2a;
                        mul2_b   <= sel_m2b;
                    end
                end
                WAIT_DONE: begin
                    cnt <= cnt + 1'b1;
                    // A done arriving on the timeout cycle still counts as a clean finish.
                    if (acc_done || tmo_hit) begin
                        acc_mode_32bit <= 1'b0;
                        if (!acc_done) timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
